// File: rtl/miniscule_acc_cpu.sv
// Miniscule accumulator CPU: multicycle FETCH/DECODE/EXEC(/MEM) control, 16-bit ACC/SP/PC/IR,
// a small ALU and a unified instruction/data memory. Datapath internals are exported as *Test ports.
module miniscule_acc_cpu #(
    parameter int unsigned MEM_DEPTH = 1024,
    parameter logic [15:0] SP_RESET  = 16'h03FF
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [15:0] FPGAIn,
    output logic [15:0] FPGAOut,
    output logic [15:0] IROutBranch,
    output logic [15:0] PCOutTest,
    output logic [15:0] MemoutTest,
    output logic [15:0] InTest,
    output logic        PCWriteTest,
    output logic        IRWriteTest,
    output logic [15:0] ACCTest,
    output logic [15:0] SPTest,
    output logic        MemWriteTest,
    output logic [1:0]  MemAddrTest,
    output logic        AluZeroTest,
    output logic        ALUovflTest,
    output logic [15:0] ALUOutTest
);

    localparam int unsigned AddrW = $clog2(MEM_DEPTH);

    localparam logic [4:0] OpAddi  = 5'b00000;
    localparam logic [4:0] OpOri   = 5'b00001;
    localparam logic [4:0] OpAndi  = 5'b00010;
    localparam logic [4:0] OpLui   = 5'b00011;
    localparam logic [4:0] OpSli   = 5'b00100;
    localparam logic [4:0] OpSri   = 5'b00101;
    localparam logic [4:0] OpLw    = 5'b00110;
    localparam logic [4:0] OpSw    = 5'b00111;
    localparam logic [4:0] OpIn    = 5'b01000;
    localparam logic [4:0] OpOut   = 5'b01001;
    localparam logic [4:0] OpBeqz  = 5'b01010;
    localparam logic [4:0] OpJ     = 5'b01011;
    localparam logic [4:0] OpAddsp = 5'b01100;

    typedef enum logic [1:0] {StFetch, StDecode, StExec, StMem} stateT;

    stateT       stateQ, stateD;
    logic [15:0] pcQ, pcD, irQ, irD, accQ, accD, spQ, spD, outQ, outD;
    logic [15:0] mem [MEM_DEPTH];

    logic [4:0]       opcode;
    logic [15:0]      sext, zext;
    logic [15:0]      aluA, aluB, addSum, aluOut;
    logic             isAdd;
    logic [1:0]       memAddrSel;
    logic [AddrW-1:0] memAddr;
    logic [15:0]      memOut;
    logic             pcWrite, irWrite, memWrite;

    assign opcode = irQ[15:11];
    assign sext   = {{5{irQ[10]}}, irQ[10:0]};
    assign zext   = {5'b00000, irQ[10:0]};

    // ALU: PC+1 during fetch, otherwise the operation selected by the opcode.
    always_comb begin
        aluA  = accQ;
        aluB  = sext;
        isAdd = 1'b1;
        if (stateQ == StFetch) begin
            aluA = pcQ;
            aluB = 16'd1;
        end else if (opcode == OpBeqz) begin
            aluA = pcQ;
        end else if (opcode == OpAddsp) begin
            aluA = spQ;
        end
        addSum = aluA + aluB;
        aluOut = addSum;
        if (stateQ != StFetch) begin
            case (opcode)
                OpOri:   begin aluOut = accQ | zext;            isAdd = 1'b0; end
                OpAndi:  begin aluOut = accQ & zext;            isAdd = 1'b0; end
                OpLui:   begin aluOut = {irQ[7:0], 8'h00};      isAdd = 1'b0; end
                OpSli:   begin aluOut = accQ << irQ[3:0];       isAdd = 1'b0; end
                OpSri:   begin aluOut = accQ >> irQ[3:0];       isAdd = 1'b0; end
                default: ;
            endcase
        end
    end

    // Memory address select: immediate address only while a load/store is in flight.
    always_comb begin
        memAddrSel = 2'd0;
        if ((stateQ == StExec || stateQ == StMem) && (opcode == OpLw || opcode == OpSw)) begin
            memAddrSel = 2'd1;
        end
    end

    // Address mux and asynchronous memory read.
    always_comb begin
        case (memAddrSel)
            2'd1:    memAddr = irQ[AddrW-1:0];
            2'd2:    memAddr = spQ[AddrW-1:0];
            default: memAddr = pcQ[AddrW-1:0];
        endcase
        memOut = mem[memAddr];
    end

    // Control FSM next state and architectural register updates.
    always_comb begin
        stateD   = stateQ;
        pcD      = pcQ;
        irD      = irQ;
        accD     = accQ;
        spD      = spQ;
        outD     = outQ;
        pcWrite  = 1'b0;
        irWrite  = 1'b0;
        memWrite = 1'b0;
        unique case (stateQ)
            StFetch: begin
                irWrite = 1'b1;
                pcWrite = 1'b1;
                irD     = memOut;
                pcD     = aluOut;
                stateD  = StDecode;
            end
            StDecode: stateD = StExec;
            StExec: begin
                stateD = StFetch;
                case (opcode)
                    OpAddi, OpOri, OpAndi, OpLui, OpSli, OpSri: accD = aluOut;
                    OpLw, OpSw: stateD = StMem;
                    OpIn:  accD = FPGAIn;
                    OpOut: outD = accQ;
                    OpBeqz: begin
                        if (accQ == 16'd0) begin
                            pcWrite = 1'b1;
                            pcD     = aluOut;
                        end
                    end
                    OpJ: begin
                        pcWrite = 1'b1;
                        pcD     = zext;
                    end
                    OpAddsp: spD = aluOut;
                    default: ;
                endcase
            end
            StMem: begin
                stateD = StFetch;
                if (opcode == OpLw) begin
                    accD = memOut;
                end else begin
                    memWrite = 1'b1;
                end
            end
        endcase
    end

    // Architectural state; reset aborts any instruction in progress.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            stateQ <= StFetch;
            pcQ    <= 16'd0;
            irQ    <= 16'd0;
            accQ   <= 16'd0;
            spQ    <= SP_RESET;
            outQ   <= 16'd0;
        end else begin
            stateQ <= stateD;
            pcQ    <= pcD;
            irQ    <= irD;
            accQ   <= accD;
            spQ    <= spD;
            outQ   <= outD;
        end
    end

    // Memory contents survive reset; a write only happens from the MEM state.
    always_ff @(posedge CLK) begin
        if (memWrite) begin
            mem[memAddr] <= accQ;
        end
    end

    assign FPGAOut      = outQ;
    assign IROutBranch  = irQ;
    assign PCOutTest    = pcQ;
    assign MemoutTest   = memOut;
    assign InTest       = FPGAIn;
    assign PCWriteTest  = pcWrite;
    assign IRWriteTest  = irWrite;
    assign ACCTest      = accQ;
    assign SPTest       = spQ;
    assign MemWriteTest = memWrite;
    assign MemAddrTest  = memAddrSel;
    assign AluZeroTest  = (aluOut == 16'd0);
    assign ALUovflTest  = isAdd & (aluA[15] == aluB[15]) & (addSum[15] != aluA[15]);
    assign ALUOutTest   = aluOut;

endmodule

// File: tb/tb_miniscule_acc_cpu.sv
// Bench for miniscule_acc_cpu: an instruction-level model checked every cycle, plus directed
// programs with hand-computed results.
module tb_miniscule_acc_cpu;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] FPGAIn = 16'h0000;
    logic [15:0] FPGAOut, IROutBranch, PCOutTest, MemoutTest, InTest, ACCTest, SPTest, ALUOutTest;
    logic        PCWriteTest, IRWriteTest, MemWriteTest, AluZeroTest, ALUovflTest;
    logic [1:0]  MemAddrTest;

    always #5 CLK = ~CLK;

    miniscule_acc_cpu dut (
        .CLK(CLK), .reset(reset), .FPGAIn(FPGAIn), .FPGAOut(FPGAOut),
        .IROutBranch(IROutBranch), .PCOutTest(PCOutTest), .MemoutTest(MemoutTest),
        .InTest(InTest), .PCWriteTest(PCWriteTest), .IRWriteTest(IRWriteTest),
        .ACCTest(ACCTest), .SPTest(SPTest), .MemWriteTest(MemWriteTest),
        .MemAddrTest(MemAddrTest), .AluZeroTest(AluZeroTest), .ALUovflTest(ALUovflTest),
        .ALUOutTest(ALUOutTest)
    );

    int checks = 0;
    int errors = 0;

    // Instruction-level model: registers, memory image and position within the instruction.
    logic [15:0] mMem [1024];
    logic [15:0] mPc, mIr, mAcc, mSp, mOut, curInstr;
    int          phase;
    bit          running = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] enc(input int op, input int imm);
        return 16'((op << 11) | (imm & 'h7FF));
    endfunction

    function automatic logic [15:0] sx(input logic [15:0] instr);
        int v;
        v = int'(instr & 16'h07FF);
        if (v >= 1024) v -= 2048;
        return 16'(v);
    endfunction

    function automatic logic [15:0] zx(input logic [15:0] instr);
        return instr & 16'h07FF;
    endfunction

    function automatic logic [15:0] aluResult(input logic [15:0] instr);
        int op;
        int sh;
        op = int'(instr >> 11);
        sh = int'(instr & 16'h000F);
        case (op)
            0:       return mAcc + sx(instr);
            1:       return mAcc | zx(instr);
            2:       return mAcc & zx(instr);
            3:       return 16'((instr & 16'h00FF) * 256);
            4:       return (sh >= 16) ? 16'h0000 : 16'(mAcc * (2 ** sh));
            default: return (sh >= 16) ? 16'h0000 : 16'(mAcc / (2 ** sh));
        endcase
    endfunction

    // Apply the whole instruction to the model once its last cycle has been checked.
    task automatic commit();
        int op;
        op = int'(curInstr >> 11);
        case (op)
            0, 1, 2, 3, 4, 5: mAcc = aluResult(curInstr);
            6:  mAcc = mMem[int'(zx(curInstr)) % 1024];
            7:  mMem[int'(zx(curInstr)) % 1024] = mAcc;
            8:  mAcc = FPGAIn;
            9:  mOut = mAcc;
            10: if (mAcc == 16'h0000) mPc = mPc + sx(curInstr);
            11: mPc = zx(curInstr);
            12: mSp = mSp + sx(curInstr);
            default: ;
        endcase
    endtask

    task automatic compareCycle();
        int op;
        int sum;
        bit isMem;
        bit pcw;
        chk("pc", PCOutTest, mPc);
        chk("ir", IROutBranch, mIr);
        chk("acc", ACCTest, mAcc);
        chk("sp", SPTest, mSp);
        chk("fpgaout", FPGAOut, mOut);
        chk("intest", InTest, FPGAIn);
        op = int'(curInstr >> 11);
        isMem = (op == 6) || (op == 7);
        case (phase)
            0: begin
                chk("irwrite_f", 16'(IRWriteTest), 16'd1);
                chk("pcwrite_f", 16'(PCWriteTest), 16'd1);
                chk("memwrite_f", 16'(MemWriteTest), 16'd0);
                chk("memaddr_f", 16'(MemAddrTest), 16'd0);
                chk("memout_f", MemoutTest, mMem[int'(mPc) % 1024]);
                curInstr = mMem[int'(mPc) % 1024];
                mIr = curInstr;
                mPc = mPc + 16'd1;
                phase = 1;
            end
            1: begin
                chk("irwrite_d", 16'(IRWriteTest), 16'd0);
                chk("pcwrite_d", 16'(PCWriteTest), 16'd0);
                chk("memwrite_d", 16'(MemWriteTest), 16'd0);
                chk("memaddr_d", 16'(MemAddrTest), 16'd0);
                phase = 2;
            end
            2: begin
                pcw = (op == 11) || (op == 10 && mAcc == 16'h0000);
                chk("irwrite_e", 16'(IRWriteTest), 16'd0);
                chk("pcwrite_e", 16'(PCWriteTest), 16'(pcw));
                chk("memwrite_e", 16'(MemWriteTest), 16'd0);
                chk("memaddr_e", 16'(MemAddrTest), 16'(isMem));
                if (op <= 5) begin
                    chk("aluout", ALUOutTest, aluResult(curInstr));
                    chk("aluzero", 16'(AluZeroTest), 16'(aluResult(curInstr) == 16'h0000));
                    if (op == 0) begin
                        sum = int'($signed(mAcc)) + int'($signed(sx(curInstr)));
                        chk("aluovfl", 16'(ALUovflTest), 16'(sum > 32767 || sum < -32768));
                    end
                end
                if (isMem) begin
                    phase = 3;
                end else begin
                    commit();
                    phase = 0;
                end
            end
            default: begin
                chk("irwrite_m", 16'(IRWriteTest), 16'd0);
                chk("pcwrite_m", 16'(PCWriteTest), 16'd0);
                chk("memwrite_m", 16'(MemWriteTest), 16'(op == 7));
                chk("memaddr_m", 16'(MemAddrTest), 16'd1);
                chk("memout_m", MemoutTest, mMem[int'(zx(curInstr)) % 1024]);
                commit();
                phase = 0;
            end
        endcase
    endtask

    task automatic tick();
        @(negedge CLK);
        if (running) compareCycle();
    endtask

    task automatic poke(input int addr, input logic [15:0] v);
        dut.mem[addr] = v;
        mMem[addr] = v;
    endtask

    // Hold reset and clear the low program area to NOPs.
    task automatic beginLoad();
        running = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 16; i++) poke(i, 16'hF800);
    endtask

    // Release reset between edges, pin reset values, then check the first fetch cycle.
    task automatic startProgram();
        @(posedge CLK);
        #2;
        reset = 1'b1;
        mPc = 16'h0000; mIr = 16'h0000; mAcc = 16'h0000; mSp = 16'h03FF; mOut = 16'h0000;
        curInstr = 16'h0000;
        phase = 0;
        running = 1'b1;
        #1;
        chk("rst_pc", PCOutTest, 16'h0000);
        chk("rst_acc", ACCTest, 16'h0000);
        chk("rst_sp", SPTest, 16'h03FF);
        chk("rst_ir", IROutBranch, 16'h0000);
        chk("rst_out", FPGAOut, 16'h0000);
        tick();
    endtask

    initial begin
        logic [15:0] expT1 [6];
        int wr;
        expT1 = '{16'd9, 16'd9, 16'd1, 16'h0600, 16'hC000, 16'h0C00};
        for (int i = 0; i < 1024; i++) poke(i, 16'hF800);
        repeat (2) @(posedge CLK);

        // ALU sequence
        beginLoad();
        poke(0, enc(0, 9)); poke(1, enc(1, 1)); poke(2, enc(2, 1));
        poke(3, enc(3, 6)); poke(4, enc(4, 5)); poke(5, enc(5, 4));
        startProgram();
        for (int k = 0; k < 6; k++) begin
            repeat (3) tick();
            chk("t1_acc", ACCTest, expT1[k]);
            chk("t1_model", mAcc, expT1[k]);
        end

        // ADDI -1 from zero
        beginLoad();
        poke(0, enc(0, -1));
        startProgram();
        repeat (3) tick();
        chk("addi_neg", ACCTest, 16'hFFFF);

        // Signed overflow 7FFF + 1
        beginLoad();
        poke(0, enc(3, 16'h7F)); poke(1, enc(1, 16'hFF)); poke(2, enc(0, 1));
        startProgram();
        repeat (8) tick();
        chk("ovfl_flag", 16'(ALUovflTest), 16'd1);
        chk("ovfl_alu", ALUOutTest, 16'h8000);
        tick();
        chk("ovfl_acc", ACCTest, 16'h8000);

        // Store, clear, load back; single write pulse
        beginLoad();
        poke(0, enc(3, 6)); poke(1, enc(7, 16'h100)); poke(2, enc(2, 0)); poke(3, enc(6, 16'h100));
        startProgram();
        wr = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (MemWriteTest) wr++;
        end
        chk("sw_pulses", 16'(wr), 16'd1);
        chk("lw_acc", ACCTest, 16'h0600);

        // IN then OUT
        beginLoad();
        FPGAIn = 16'hA5A5;
        poke(0, enc(8, 0)); poke(1, enc(9, 0));
        startProgram();
        repeat (6) tick();
        chk("io_out", FPGAOut, 16'hA5A5);
        chk("io_acc", ACCTest, 16'hA5A5);

        // BEQZ taken
        beginLoad();
        poke(0, enc(10, 2)); poke(1, enc(0, 1)); poke(2, enc(0, 2)); poke(3, enc(0, 4));
        startProgram();
        repeat (6) tick();
        chk("beqz_t_pc", PCOutTest, 16'd4);
        chk("beqz_t_acc", ACCTest, 16'd4);

        // BEQZ not taken
        beginLoad();
        poke(0, enc(0, 1)); poke(1, enc(10, 2)); poke(2, enc(0, 2)); poke(3, enc(0, 4));
        startProgram();
        repeat (9) tick();
        chk("beqz_n_pc", PCOutTest, 16'd3);
        chk("beqz_n_acc", ACCTest, 16'd3);

        // ADDSP and J
        beginLoad();
        poke(0, enc(12, -1)); poke(1, enc(11, 5)); poke(5, enc(0, 7));
        startProgram();
        repeat (9) tick();
        chk("addsp_sp", SPTest, 16'h03FE);
        chk("j_acc", ACCTest, 16'd7);
        chk("j_pc", PCOutTest, 16'd6);

        // Reset during EXEC of a store: immediate clear, store never lands
        beginLoad();
        poke(16'h200, 16'h0BAD);
        poke(0, enc(0, 5)); poke(1, enc(12, 3)); poke(2, enc(7, 16'h200));
        startProgram();
        repeat (6) tick();
        chk("mid_acc", ACCTest, 16'd5);
        chk("mid_sp", SPTest, 16'h0402);
        repeat (2) tick();
        chk("mid_exec_maddr", 16'(MemAddrTest), 16'd1);
        running = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("abort_pc", PCOutTest, 16'h0000);
        chk("abort_acc", ACCTest, 16'h0000);
        chk("abort_sp", SPTest, 16'h03FF);
        repeat (2) @(posedge CLK);
        beginLoad();
        poke(0, enc(6, 16'h200));
        startProgram();
        repeat (4) tick();
        chk("abort_nowrite", ACCTest, 16'h0BAD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
